rr_arb_n: RTL and testbench
===========================

RR_ARB_N -- requirements
Module: rr_arb_n

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters, legal range 2..16, need not be a power of two.
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum consecutive locked-hold cycles, legal range 1..255.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N  per-requester request.
REQ-007 SHALL have port lock  input  N  per-requester hold request; only the current owner's bit is used.
REQ-008 SHALL have port grant  output  N  registered one-hot grant, or zero.
REQ-009 SHALL have port grant_valid  output  1  high when grant is non-zero.
REQ-010 SHALL have port grant_id  output  clog2(N), min 1  index of the set grant bit; 0 when grant_valid=0.

Function
REQ-011 SHALL hold state: grant register (one-hot), priority pointer ptr (0..N-1), hold counter hold_cnt (8 bits).
REQ-012 SHALL drive grant, grant_valid and grant_id from registers only; they carry no combinational path from req or lock.
REQ-013 SHALL update all state on each rising clk edge; a req change is reflected in grant one cycle later.
REQ-014 SHALL keep the grant unchanged and increment hold_cnt when: an owner exists, req[owner]=1, lock[owner]=1, and hold_cnt < MAX_HOLD-1.
REQ-015 SHALL otherwise arbitrate: winner is the first requester with req=1, searching ptr, ptr+1, ... modulo N.
REQ-016 SHALL, on a win, set grant to one-hot of the winner, set ptr = (winner+1) mod N, and set hold_cnt=0.
REQ-017 SHALL clear grant when no req bit is set at an arbitration point; ptr is unchanged.
REQ-018 SHALL release an owner whose req drops to 0 at the next edge, even if lock=1; arbitration occurs at that same edge.
REQ-019 SHALL give a non-locked owner whose req stays high no priority over others; ptr has already advanced past it.
REQ-020 SHALL compute the modulo-N wrap correctly for non-power-of-two N; ptr shall never hold a value >= N.
REQ-021 SHALL ignore lock bits of non-owners and lock bits without a matching req.

Reset
REQ-022 SHALL, while reset=0, asynchronously force grant=0, grant_valid=0, grant_id=0, ptr=0 and hold_cnt=0.
REQ-023 SHALL make the first arbitration after reset release search from index 0.
REQ-024 SHALL abandon any lock in progress when reset is asserted; no hold state survives reset.

Configuration
REQ-025 SHALL support the macro ARB_HOLD_LIMIT_EN.
REQ-026 SHALL, when ARB_HOLD_LIMIT_EN is defined, end a hold when hold_cnt reaches MAX_HOLD-1: the owner is excluded from that arbitration, so the grant moves to the next requester in priority order.
REQ-027 SHALL, in that forced-release case, re-grant the owner (hold_cnt=0, ptr=owner+1) if it is the only requester.
REQ-028 SHALL, when ARB_HOLD_LIMIT_EN is not defined, let a lock hold indefinitely; hold_cnt logic and MAX_HOLD are then unused and may be removed.

Verification (N=4, MAX_HOLD=4)
REQ-029 SHALL cover: reset=0 with req=1111 -> grant=0000, grant_valid=0, grant_id=0; after release, first grant=0001.
REQ-030 SHALL cover: req=1111, lock=0 -> grant sequence 0001, 0010, 0100, 1000, 0001 on successive cycles.
REQ-031 SHALL cover: req=0101, lock=0 -> grant alternates 0001, 0100, 0001; grant_id alternates 0, 2.
REQ-032 SHALL cover: req=1111, owner 1 holds lock[1]=1 for 3 cycles, then drops it -> grant 0010 held 3 cycles, then 0100.
REQ-033 SHALL cover, with ARB_HOLD_LIMIT_EN defined: req=1111, lock=1111 -> each grant lasts exactly 4 cycles in order 0001, 0010, 0100, 1000. With req=0010 only, grant stays 0010 continuously.
REQ-034 SHALL cover: reset asserted mid-lock while grant=0100 -> grant=0000 immediately, before the next clk edge. With req=1111 after release, the first grant is 0001.

Source files
------------

// File: rtl/rr_arb_n.sv
// N-way round-robin arbiter with per-owner lock (hold) and registered one-hot grant.
// Optional macro ARB_HOLD_LIMIT_EN caps a locked hold at MAX_HOLD consecutive cycles.
module rr_arb_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  lock,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    localparam int        EW        = IW + 1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [N-1:0]  grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;

    logic          owner_locked;
    logic          limit_hit;
    logic          hold;
    logic [N-1:0]  excl_req;
    logic [N-1:0]  arb_req;
    logic [IW-1:0] rot_idx [N];
    logic          found;
    logic [IW-1:0] win_idx;

    // Only the current owner's lock counts, and only while it still requests.
    assign owner_locked = |(grant_q & req & lock);

`ifdef ARB_HOLD_LIMIT_EN
    assign limit_hit = owner_locked && (hold_cnt_q >= HOLD_LAST);
`else
    assign limit_hit = 1'b0;
`endif

    assign hold     = owner_locked && !limit_hit;
    assign excl_req = req & ~grant_q;
    // A forced release skips the owner unless nobody else is asking.
    assign arb_req  = (limit_hit && (|excl_req)) ? excl_req : req;

    // Search order ptr, ptr+1, ... wrapped modulo N (works for any N, not only powers of two).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [EW-1:0] sum;
            assign sum         = {1'b0, ptr_q} + EW'(gi);
            assign rot_idx[gi] = IW'((sum >= EW'(N)) ? (sum - EW'(N)) : sum);
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && arb_req[rot_idx[i]]) begin
                found   = 1'b1;
                win_idx = rot_idx[i];
            end
        end
    end

    always_comb begin
        grant_d    = grant_q;
        valid_d    = valid_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (hold) begin
            if (hold_cnt_q < HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end else if (found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            valid_d          = 1'b1;
            id_d             = win_idx;
            ptr_d            = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
            hold_cnt_d       = 8'd0;
        end else begin
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= 8'd0;
        end else begin
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arb_n.sv
// Self-checking bench for rr_arb_n (N=4, MAX_HOLD=4): directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_rr_arb_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    int n_cmp;
    int n_bad;

    // Reference model: owner index (-1 = none), pointer, consecutive hold count.
    int m_owner;
    int m_ptr;
    int m_cnt;

    rr_arb_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        bit keep;
        bit forced;
        int winner;
        int c;
        keep   = (m_owner >= 0) && r[m_owner] && l[m_owner];
        forced = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        if (keep && (m_cnt >= MAX_HOLD - 1)) begin
            keep   = 1'b0;
            forced = 1'b1;
        end
`endif
        if (keep) begin
            m_cnt = m_cnt + 1;
        end else begin
            winner = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (winner < 0 && r[c] && !(forced && c == m_owner)) winner = c;
            end
            if (winner < 0 && forced) winner = m_owner;
            if (winner >= 0) begin
                m_owner = winner;
                m_ptr   = (winner + 1) % N;
                m_cnt   = 0;
            end else begin
                m_owner = -1;
            end
        end
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // Drive one cycle of inputs, advance one clock edge, update the model, settle.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        $display("t=%0t req=%b lock=%b grant=%b valid=%b id=%0d", $time, r, l, grant, grant_valid, grant_id);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b1111;
        lock  = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_cmp++;
        if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
        n_cmp++;
        if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
        reset = 1'b1;
        step(4'b1111, 4'b0000);
        n_cmp++;
        if (grant !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant got=%b exp=0001", grant); end
    endtask

    task automatic test_rotate();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0000);
            n_cmp++;
            if (grant !== exp_seq[k]) begin
                n_bad++; $display("FAIL rotate[%0d] got=%b exp=%b", k, grant, exp_seq[k]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0]  exp_g  [4];
        logic [IW-1:0] exp_id [4];
        exp_g  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        exp_id = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0101, 4'b0000);
            n_cmp++;
            if (grant !== exp_g[k]) begin
                n_bad++; $display("FAIL alternate_grant[%0d] got=%b exp=%b", k, grant, exp_g[k]);
            end
            n_cmp++;
            if (grant_id !== exp_id[k] || grant_valid !== 1'b1) begin
                n_bad++; $display("FAIL alternate_id[%0d] got=%0d/%b exp=%0d/1", k, grant_id, grant_valid, exp_id[k]);
            end
        end
    endtask

    task automatic test_lock_release();
        do_reset();
        step(4'b1111, 4'b0000);
        // Owner 1 wins this edge and keeps lock[1] for its three cycles.
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 4'b0010);
            n_cmp++;
            if (grant !== 4'b0010) begin
                n_bad++; $display("FAIL lock_hold[%0d] got=%b exp=0010", k, grant);
            end
        end
        step(4'b1111, 4'b0000);
        n_cmp++;
        if (grant !== 4'b0100) begin n_bad++; $display("FAIL lock_release got=%b exp=0100", grant); end
        // Owner dropping req is released even with lock still set.
        step(4'b1011, 4'b0100);
        n_cmp++;
        if (grant !== 4'b1000) begin n_bad++; $display("FAIL req_drop_release got=%b exp=1000", grant); end
    endtask

    task automatic test_hold_limit();
        logic [N-1:0] exp_g;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(4'b1111, 4'b1111);
`ifdef ARB_HOLD_LIMIT_EN
            exp_g = 4'b0001 << (k / MAX_HOLD);
`else
            exp_g = 4'b0001;
`endif
            n_cmp++;
            if (grant !== exp_g) begin
                n_bad++; $display("FAIL hold_all[%0d] got=%b exp=%b", k, grant, exp_g);
            end
        end
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(4'b0010, 4'b1111);
            n_cmp++;
            if (grant !== 4'b0010 || grant_id !== 2'd1) begin
                n_bad++; $display("FAIL hold_sole[%0d] got=%b/%0d exp=0010/1", k, grant, grant_id);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0100);
        step(4'b1111, 4'b0100);
        n_cmp++;
        if (grant !== 4'b0100) begin n_bad++; $display("FAIL midlock_setup got=%b exp=0100", grant); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            n_bad++; $display("FAIL midlock_async_clear got=%b/%b/%0d exp=0000/0/0", grant, grant_valid, grant_id);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(4'b1111, 4'b0100);
        n_cmp++;
        if (grant !== 4'b0001) begin n_bad++; $display("FAIL midlock_after_reset got=%b exp=0001", grant); end
    endtask

    task automatic test_random();
        logic [N-1:0]  r;
        logic [N-1:0]  l;
        logic [N-1:0]  exp_g;
        logic [IW-1:0] exp_id;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            step(r, l);
            exp_g  = model_grant();
            exp_id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            n_cmp++;
            if (grant !== exp_g) begin
                n_bad++; $display("FAIL rand_grant[%0d] got=%b exp=%b", k, grant, exp_g);
            end
            n_cmp++;
            if (grant_valid !== (m_owner >= 0)) begin
                n_bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", k, grant_valid, (m_owner >= 0));
            end
            n_cmp++;
            if (grant_id !== exp_id) begin
                n_bad++; $display("FAIL rand_id[%0d] got=%0d exp=%0d", k, grant_id, exp_id);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        model_reset();
        #2;
        test_reset();
        test_rotate();
        test_alternate();
        test_lock_release();
        test_hold_limit();
        test_reset_mid_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
